// File: rtl/rca_mp_sequencer.sv
// rtl/rca_mp_sequencer.sv - multi-precision add/sub sequencer over one shared W-bit ripple-carry adder.
// Two round-robin requesters; operands are processed LSW first with the carry registered between beats.

module RippleCarryAdder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);
  always_comb begin : ripple
    logic c;
    s_o = '0;
    c   = cin_i;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

module rca_mp_sequencer #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [W*WORDS-1:0]   in0_a,
  input  logic [W*WORDS-1:0]   in0_b,
  input  logic                 in0_sub,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [W*WORDS-1:0]   in1_a,
  input  logic [W*WORDS-1:0]   in1_b,
  input  logic                 in1_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 out_id
);
  localparam int N  = W * WORDS;
  localparam int BW = $clog2(WORDS);
  localparam logic [BW-1:0] LAST = BW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic            last_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            carry_q;
  logic [BW-1:0]   beat_q;
  logic            id_q;
  logic [N-W-1:0]  sum_q;
  logic [N-1:0]    out_sum_q;
  logic            out_cout_q;
  logic            out_ovf_q;
  logic            out_id_q;
  logic            out_valid_q;

  logic            gnt1;
  logic            req_any;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic            sel_sub;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic [W-1:0]    add_s;
  logic            add_cout;

  // Requester 1 wins a tie only when requester 0 held the last grant.
  assign req_any = in0_valid | in1_valid;
  assign gnt1    = in1_valid & (~in0_valid | ~last_q);

  assign in0_ready = ~rst & (state_q == IDLE) & req_any & ~gnt1;
  assign in1_ready = ~rst & (state_q == IDLE) & gnt1;

  always_comb begin
    sel_a   = in0_a;
    sel_b   = in0_b;
    sel_sub = in0_sub;
    if (gnt1) begin
      sel_a   = in1_a;
      sel_b   = in1_b;
      sel_sub = in1_sub;
    end
  end

  assign add_a = a_q[int'(beat_q) * W +: W];
  assign add_b = b_q[int'(beat_q) * W +: W];

  RippleCarryAdder #(.W(W)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      beat_q      <= '0;
      id_q        <= 1'b0;
      sum_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_id_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            a_q     <= sel_a;
            b_q     <= sel_sub ? ~sel_b : sel_b;
            carry_q <= sel_sub;
            beat_q  <= '0;
            id_q    <= gnt1;
            last_q  <= gnt1;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= add_cout;
          beat_q  <= beat_q + 1'b1;
          if (beat_q != LAST) begin
            sum_q[int'(beat_q) * W +: W] <= add_s;
          end else begin
            // The result register only changes here, so no partial sum is ever visible.
            out_sum_q   <= {add_s, sum_q};
            out_cout_q  <= add_cout;
            out_ovf_q   <= (a_q[N-1] == b_q[N-1]) && (add_s[W-1] != a_q[N-1]);
            out_id_q    <= id_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_id    = out_id_q;
endmodule

// File: tb/tb_rca_mp_sequencer.sv
// tb/tb_rca_mp_sequencer.sv - directed bench for rca_mp_sequencer with a cycle-level reference model.
module tb_rca_mp_sequencer;
  localparam int W = 16;
  localparam int WORDS = 4;
  localparam int N = W * WORDS;

  logic clk = 0;
  logic rst;
  logic in0_valid, in1_valid, in0_sub, in1_sub, out_ready;
  logic [N-1:0] in0_a, in0_b, in1_a, in1_b;
  logic in0_ready, in1_ready, out_valid, out_cout, out_ovf, out_id;
  logic [N-1:0] out_sum;

  int n_pass = 0;
  int n_chk = 0;
  int cyc = 0;

  rca_mp_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b), .in0_sub(in0_sub),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b), .in1_sub(in1_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_id(out_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Reference arithmetic: full-width add or a + ~b + 1, signed overflow from operand/result signs.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    logic [N:0] r;
    logic ovf;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 1;
    else     r = {1'b0, a} + {1'b0, b};
    if (sub) ovf = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
    else     ovf = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
    return {ovf, r};
  endfunction

  // Model: 0 idle, 1 busy (counting beats), 2 result presented.
  int m_state = 0;
  int m_cnt = 0;
  logic m_last = 1'b1;
  logic [N-1:0] m_sum = '0;
  logic m_cout = 0, m_ovf = 0, m_id = 0, m_pid = 0;
  logic [N+1:0] m_pend;

  always @(negedge clk) begin
    logic g;
    logic any;
    if (rst) begin
      m_state = 0; m_last = 1'b1; m_sum = '0; m_cout = 0; m_ovf = 0; m_id = 0;
      chk("rst_ready0", in0_ready, 0);
      chk("rst_ready1", in1_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_flags", {out_cout, out_ovf, out_id}, 0);
    end else begin
      any = in0_valid | in1_valid;
      if (in0_valid && in1_valid) g = ~m_last;
      else g = in1_valid;
      chk("m_ready0", in0_ready, (m_state == 0) && any && !g);
      chk("m_ready1", in1_ready, (m_state == 0) && any && g);
      chk("m_out_valid", out_valid, m_state == 2);
      chk("m_out_sum", out_sum, m_sum);
      chk("m_out_cout", out_cout, m_cout);
      chk("m_out_ovf", out_ovf, m_ovf);
      chk("m_out_id", out_id, m_id);
      case (m_state)
        0: if (any) begin
          m_pend = g ? model(in1_a, in1_b, in1_sub) : model(in0_a, in0_b, in0_sub);
          m_pid = g; m_last = g; m_cnt = WORDS; m_state = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_state = 2;
            m_sum = m_pend[N-1:0]; m_cout = m_pend[N]; m_ovf = m_pend[N+1]; m_id = m_pid;
          end
        end
        default: if (out_ready) m_state = 0;
      endcase
    end
  end

  task automatic do_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input logic [N-1:0] es, input logic ec, input logic eo);
    int n;
    bit got;
    @(posedge clk); #1;
    if (idx == 0) begin in0_a = a; in0_b = b; in0_sub = sub; in0_valid = 1; end
    else          begin in1_a = a; in1_b = b; in1_sub = sub; in1_valid = 1; end
    got = 0;
    for (n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (idx == 0) ? in0_ready : in1_ready;
    end
    if (!got) timeout("op_handshake");
    @(posedge clk); #1;
    in0_valid = 0; in1_valid = 0;
    got = 0;
    for (n = 1; n < 20 && !got; n++) begin
      @(negedge clk);
      got = out_valid;
      if (got) break;
    end
    if (!got) timeout("op_out_valid");
    else begin
      chk("op_latency", n, 5);
      chk("op_sum", out_sum, es);
      chk("op_cout", out_cout, ec);
      chk("op_ovf", out_ovf, eo);
      chk("op_id", out_id, idx[0]);
    end
  endtask

  task automatic wait_hs(output int c, output logic id);
    bit got = 0;
    c = -1; id = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (in0_ready || in1_ready) begin got = 1; c = cyc; id = in1_ready; end
    end
    if (!got) timeout("handshake");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc[4];
    logic hid[4];
    logic exp_ids[4];
    int v, c;
    logic id;
    bit got;
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1; out_ready = 1;
    in0_valid = 0; in1_valid = 0; in0_sub = 0; in1_sub = 0;
    in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // Directed arithmetic cases
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0);
    do_op(0, 64'h0000_0000_0001_0000, 64'd1, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
    do_op(1, 64'h0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    do_op(1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Round-robin from reset release
    @(posedge clk); #2 rst = 1;
    in0_a = 64'h1234_5678_9ABC_DEF0; in0_b = 64'h0FED_CBA9_8765_4321; in0_sub = 0;
    in1_a = 64'd5; in1_b = 64'd7; in1_sub = 1;
    in0_valid = 1; in1_valid = 1;
    @(posedge clk); #2 rst = 0;
    for (int i = 0; i < 4; i++) begin
      wait_hs(hc[i], hid[i]);
      chk("rr_id", hid[i], exp_ids[i]);
      if (i > 0) chk("rr_spacing", hc[i] - hc[i-1], 6);
    end

    // Output backpressure with both requesters still valid
    @(posedge clk); #1 out_ready = 0;
    got = 0; v = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; v = cyc; end
    end
    if (!got) timeout("bp_out_valid");
    chk("bp_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("bp_id", out_id, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    wait_hs(c, id);
    chk("bp_next_grant_cycle", c - v, 4);
    chk("bp_next_grant_id", id, 0);

    // Reset during beat 2 of a requester-1 operation
    @(posedge clk); #1 in0_valid = 0; in1_valid = 0;
    repeat (10) @(posedge clk);
    #1 in1_a = 64'd3; in1_b = 64'd4; in1_sub = 0; in1_valid = 1;
    wait_hs(c, id);
    chk("rst_op_id", id, 1);
    @(posedge clk); #1 in1_valid = 0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("rst_no_result", out_valid, 0);
    end
    @(posedge clk); #1 in0_valid = 1; in1_valid = 1;
    wait_hs(c, id);
    chk("rst_first_grant", id, 0);
    @(posedge clk); #1 in0_valid = 0; in1_valid = 0;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rca_mp_sequencer.md
# rca_mp_sequencer

Multi-precision add/subtract controller built around one shared 16-bit `RippleCarryAdder` instance. It arbitrates between two requesters, then runs the adder over WORDS beats, least-significant word first. The carry is registered between beats, giving a W*WORDS-bit result. It sits between operand producers and the adder datapath, so wide arithmetic needs no wider adder.

## Interface
- `W`, 16, adder word width; must match the `RippleCarryAdder` instance width.
- `WORDS`, 4, number of beats per operation; operand width is W*WORDS; legal range 2..8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `in0_valid`, `in1_valid`  in  1  request valid, one per requester.
- `in0_ready`, `in1_ready`  out  1  request accepted this cycle.
- `in0_a`, `in0_b`, `in1_a`, `in1_b`  in  W*WORDS  operands.
- `in0_sub`, `in1_sub`  in  1  1 = a−b, 0 = a+b.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  W*WORDS  result.
- `out_cout`  out  1  final adder carry-out; for sub, 1 = no borrow.
- `out_ovf`  out  1  two's-complement signed overflow.
- `out_id`  out  1  index of the requester that owns the result.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - If any `inX_valid` is high, grant one requester. In the same cycle, assert the granted `inX_ready` combinationally; the other ready stays 0.
  - On the edge, capture:
    - a;
    - b, inverted when sub;
    - carry register = sub;
    - beat counter = 0;
    - id = the granted requester.
  - Go to RUN.
- **Arbitration**
  - Round-robin over the two requesters. The last-grant pointer resets so requester 0 wins the first tie.
  - When both are valid, grant the requester not granted last.
  - A lone valid requester is always granted, even back-to-back.
- **RUN**
  - On beat k, feed word k of a and of b' (bits k*W+W−1 : k*W) to the adder, with Cin = carry register.
  - On the edge, store S into result word k and load Cout into the carry register, then increment k.
  - After beat WORDS−1: latch `out_cout` = Cout and set `out_ovf` = (a_msb == b'_msb) && (S_msb != a_msb). Go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `out_sum`, `out_cout`, `out_ovf` and `out_id` are held stable until `out_valid` && `out_ready`, then the FSM returns to IDLE.
- Both `inX_ready` are 0 in RUN and DONE. Requesters hold valid and data until ready; a dropped valid is simply not granted.
- Reset values: state IDLE, `out_valid` = 0, both readies 0, `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0, `out_id` = 0, pointer favouring requester 0.
- `rst` asserted in any state aborts the operation:
  - outputs go to their reset values immediately;
  - no partial result is ever presented.

## Timing
- Request handshake in cycle c: RUN occupies cycles c+1..c+WORDS, and `out_valid` rises in cycle c+WORDS+1 (c+5 for WORDS=4).
- With `out_ready` held at 1, DONE lasts 1 cycle. The earliest next handshake is in cycle c+WORDS+2, so peak throughput is one operation per WORDS+2 cycles.
- The adder is purely combinational. Its path is one W-bit ripple per cycle and does not span beats.
- `out_ready` low stalls in DONE indefinitely with all outputs stable. No new request is granted until the result is accepted.
- The arbitration pointer updates only on an accepted grant. A stall in DONE does not change it.

## Test plan
1. **Add with full carry.** `in0`: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, handshake in cycle c.
   - Expect `out_valid` in cycle c+5, `out_sum`=0, `out_cout`=1, `out_ovf`=0, `out_id`=0.
2. **Subtract with borrow across words.** a=0x0000_0000_0001_0000, b=1, sub=1.
   - Expect `out_sum`=0x0000_0000_0000_FFFF, `out_cout`=1.
   - Then a=0, b=1 → `out_sum`=0xFFFF_FFFF_FFFF_FFFF, `out_cout`=0.
3. **Signed overflow.** a=0x7FFF_FFFF_FFFF_FFFF, b=1, add.
   - Expect `out_sum`=0x8000_0000_0000_0000, `out_ovf`=1, `out_cout`=0.
   - Then a=0x8000_0000_0000_0000, b=1, sub → `out_ovf`=1.
4. **Round-robin.** Both requesters valid continuously from reset release, `out_ready`=1.
   - Grants and `out_id` sequence 0,1,0,1.
   - Each result matches its requester's operands.
   - Handshakes are spaced exactly 6 cycles apart.
5. **Output backpressure.** `out_ready` held 0 for 3 cycles after `out_valid` rises, with both inputs valid.
   - `out_sum`, `out_cout`, `out_ovf` and `out_id` stay stable; both readies stay 0.
   - Accepted on the 4th cycle; the next grant follows one cycle later.
6. **Reset mid-operation.** `rst` pulsed during beat 2 of a requester-1 operation.
   - `out_valid` stays 0 and no result appears.
   - After release, with both valid, the first grant goes to requester 0.
